// File: rtl/dff_sr_bank_ctrl.sv
// Command sequencer for a bank of dff_sr cells: drives per-bit D/SET_B/RESET_B strobes
// for HOLD_CYCLES clocks, samples Q after a settle cycle and reports it on a response channel.
module dff_sr_bank_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_MASK,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] SET_B,
  output logic [WIDTH-1:0] RESET_B,
  input  logic [WIDTH-1:0] Q,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESP} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SET = 2'b01, OP_CLEAR = 2'b10, OP_READ = 2'b11} op_t;

  state_t           state, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       cnt, cnt_d;
  logic [WIDTH-1:0] d_d, set_b_d, reset_b_d, rsp_data_d;
  logic             rsp_valid_d, rsp_err_d;
  logic [WIDTH-1:0] exp_val;

  assign CMD_READY = (state == IDLE) && !RESET;

  always_comb begin
    unique case (op_q)
      OP_LOAD: exp_val = data_q;
      OP_SET:  exp_val = '1;
      default: exp_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state;
    op_d        = op_q;
    mask_d      = mask_q;
    data_d      = data_q;
    cnt_d       = cnt;
    d_d         = D;
    set_b_d     = SET_B;
    reset_b_d   = RESET_B;
    rsp_valid_d = RSP_VALID;
    rsp_data_d  = RSP_DATA;
    rsp_err_d   = RSP_ERR;
    unique case (state)
      IDLE: begin
        if (CMD_VALID) begin
          op_d   = op_t'(CMD_OP);
          mask_d = CMD_MASK;
          data_d = CMD_DATA;
          if (op_t'(CMD_OP) == OP_READ) begin
            state_d = SETTLE;
          end else begin
            state_d = DRIVE;
            cnt_d   = 8'(HOLD_CYCLES);
            // Strobes are computed from the raw command so they are registered on the accept edge.
            unique case (op_t'(CMD_OP))
              OP_LOAD: begin
                d_d       = CMD_DATA & CMD_MASK;
                set_b_d   = ~CMD_MASK;
                reset_b_d = ~CMD_MASK;
              end
              OP_SET: begin
                d_d       = '0;
                set_b_d   = ~CMD_MASK;
                reset_b_d = '1;
              end
              default: begin
                d_d       = '0;
                set_b_d   = '1;
                reset_b_d = ~CMD_MASK;
              end
            endcase
          end
        end
      end
      DRIVE: begin
        if (cnt <= 8'd1) begin
          state_d   = SETTLE;
          cnt_d     = '0;
          d_d       = '0;
          set_b_d   = '1;
          reset_b_d = '1;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      SETTLE: begin
        rsp_data_d  = Q;
        rsp_err_d   = (op_q == OP_READ) ? 1'b0 : |((Q ^ exp_val) & mask_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      op_q      <= OP_LOAD;
      mask_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      D         <= '0;
      SET_B     <= '1;
      RESET_B   <= '1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      cnt       <= cnt_d;
      D         <= d_d;
      SET_B     <= set_b_d;
      RESET_B   <= reset_b_d;
      RSP_VALID <= rsp_valid_d;
      RSP_DATA  <= rsp_data_d;
      RSP_ERR   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_dff_sr_bank_ctrl.sv
// Directed bench for dff_sr_bank_ctrl: two instances (HOLD_CYCLES 1 and 3), each driving
// a behavioural dff_sr bank model; expected values are hand-computed constants.
module tb_dff_sr_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // instance A, HOLD_CYCLES = 1
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_op;
  logic [7:0] cmd_mask, cmd_data, d, set_b, reset_b, q, rsp_data;
  logic [7:0] bank, stuck, pre_val;
  logic       pre_en;

  // instance B, HOLD_CYCLES = 3
  logic       b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [1:0] b_cmd_op;
  logic [7:0] b_cmd_mask, b_cmd_data, b_d, b_set_b, b_reset_b, b_q, b_rsp_data;
  logic [7:0] b_bank, b_pre_val;
  logic       b_pre_en;

  int unsigned n_pass = 0, n_total = 0, cyc = 0, acc_cyc = 0;

  dff_sr_bank_ctrl #(.WIDTH(8), .HOLD_CYCLES(1)) dut_a (
    .CLK(clk), .RESET(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_MASK(cmd_mask), .CMD_DATA(cmd_data), .D(d), .SET_B(set_b), .RESET_B(reset_b), .Q(q),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err));

  dff_sr_bank_ctrl #(.WIDTH(8), .HOLD_CYCLES(3)) dut_b (
    .CLK(clk), .RESET(rst), .CMD_VALID(b_cmd_valid), .CMD_READY(b_cmd_ready), .CMD_OP(b_cmd_op),
    .CMD_MASK(b_cmd_mask), .CMD_DATA(b_cmd_data), .D(b_d), .SET_B(b_set_b), .RESET_B(b_reset_b),
    .Q(b_q), .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready), .RSP_DATA(b_rsp_data),
    .RSP_ERR(b_rsp_err));

  // Bank models: clocked dff_sr cells, with optional preload and stuck-at-1 bits.
  always @(posedge clk) begin
    if (pre_en) bank <= pre_val;
    else for (int b = 0; b < 8; b++)
      if (!set_b[b] && !reset_b[b]) bank[b] <= d[b];
      else if (!set_b[b])           bank[b] <= 1'b1;
      else if (!reset_b[b])         bank[b] <= 1'b0;
  end
  assign q = bank | stuck;

  always @(posedge clk) begin
    if (b_pre_en) b_bank <= b_pre_val;
    else for (int b = 0; b < 8; b++)
      if (!b_set_b[b] && !b_reset_b[b]) b_bank[b] <= b_d[b];
      else if (!b_set_b[b])             b_bank[b] <= 1'b1;
      else if (!b_reset_b[b])           b_bank[b] <= 1'b0;
  end
  assign b_q = b_bank;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    pre_val = v; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [7:0] mask,
                       input logic [7:0] data);
    cmd_op = op; cmd_mask = mask; cmd_data = data; cmd_valid = 1'b1;
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int unsigned lat, input logic [7:0] data,
                          input logic err);
    int unsigned n = 0;
    while (!rsp_valid && n < 16) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_lat"}, cyc - acc_cyc, lat);
    check({tag, "_data"}, 32'(rsp_data), 32'(data));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
  endtask

  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_mask = 0; cmd_data = 0; rsp_ready = 0;
    b_cmd_valid = 0; b_cmd_op = 0; b_cmd_mask = 0; b_cmd_data = 0; b_rsp_ready = 0;
    stuck = 8'h00; pre_en = 0; pre_val = 0; b_pre_en = 0; b_pre_val = 0;
    tick(); tick();
    check("rst_d", 32'(d), 32'h00);
    check("rst_set_b", 32'(set_b), 32'hFF);
    check("rst_reset_b", 32'(reset_b), 32'hFF);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(cmd_ready), 32'd1);

    // LOAD 0xA5, full mask
    preload(8'h00);
    issue("load", 2'b00, 8'hFF, 8'hA5);
    check("load_set_b", 32'(set_b), 32'h00);
    check("load_reset_b", 32'(reset_b), 32'h00);
    check("load_d", 32'(d), 32'hA5);
    check("load_busy", 32'(cmd_ready), 32'd0);
    wait_rsp("load", 2, 8'hA5, 1'b0);
    ack("load");

    // READ on 0x5A with RSP_READY held high: one-cycle response
    preload(8'h5A);
    issue("read", 2'b11, 8'hFF, 8'h00);
    check("read_set_b", 32'(set_b), 32'hFF);
    check("read_reset_b", 32'(reset_b), 32'hFF);
    check("read_d", 32'(d), 32'h00);
    rsp_ready = 1'b1;
    wait_rsp("read", 1, 8'h5A, 1'b0);
    tick();
    rsp_ready = 1'b0;
    check("read_one_cycle", 32'(rsp_valid), 32'd0);

    // CLEAR mask 0x81 with bit 0 stuck at 1
    stuck = 8'h01;
    preload(8'hFF);
    issue("clear", 2'b10, 8'h81, 8'h00);
    check("clear_set_b", 32'(set_b), 32'hFF);
    check("clear_reset_b", 32'(reset_b), 32'h7E);
    wait_rsp("clear", 2, 8'h7F, 1'b1);
    ack("clear");
    stuck = 8'h00;

    // LOAD with empty mask: no strobes, timing kept
    preload(8'h3C);
    issue("nomask", 2'b00, 8'h00, 8'hFF);
    check("nomask_set_b", 32'(set_b), 32'hFF);
    check("nomask_reset_b", 32'(reset_b), 32'hFF);
    check("nomask_d", 32'(d), 32'h00);
    wait_rsp("nomask", 2, 8'h3C, 1'b0);
    ack("nomask");

    // Backpressure: SET, then hold the response 5 cycles with a READ pending
    preload(8'h00);
    issue("bp_set", 2'b01, 8'hFF, 8'h00);
    wait_rsp("bp_set", 2, 8'hFF, 1'b0);
    cmd_op = 2'b11; cmd_mask = 8'hFF; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'hFF);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_drop", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    check("bp_taken", 32'(cmd_ready), 32'd0);
    wait_rsp("bp_read", 1, 8'hFF, 1'b0);
    ack("bp_read");

    // Asynchronous reset mid-DRIVE
    preload(8'h00);
    issue("rmid", 2'b01, 8'hFF, 8'h00);
    check("rmid_set_b_active", 32'(set_b), 32'h00);
    #2 rst = 1'b1;
    #1;
    check("rmid_set_b", 32'(set_b), 32'hFF);
    check("rmid_reset_b", 32'(reset_b), 32'hFF);
    check("rmid_d", 32'(d), 32'h00);
    check("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rmid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("rmid_bank", 32'(bank), 32'h00);

    // Instance B: SET mask 0x0F on 0x30, strobes held 3 cycles
    b_pre_val = 8'h30; b_pre_en = 1'b1;
    tick();
    b_pre_en = 1'b0;
    b_cmd_op = 2'b01; b_cmd_mask = 8'h0F; b_cmd_valid = 1'b1;
    check("h3_ready", 32'(b_cmd_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("h3_set_b", 32'(b_set_b), 32'hF0);
      check("h3_reset_b", 32'(b_reset_b), 32'hFF);
      tick();
    end
    check("h3_set_b_off", 32'(b_set_b), 32'hFF);
    n = 0;
    while (!b_rsp_valid && n < 16) begin
      tick();
      n++;
    end
    check("h3_valid", 32'(b_rsp_valid), 32'd1);
    check("h3_lat", cyc - acc_cyc, 32'd4);
    check("h3_data", 32'(b_rsp_data), 32'h3F);
    check("h3_err", 32'(b_rsp_err), 32'd0);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    check("h3_drop", 32'(b_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
